// File: rtl/mp_fifo_pkg.sv
// Shared helpers for the multi-port compacting FIFO: width functions, lane counting
// and the modulo-DEPTH pointer advance used by any DEPTH, power of two or not.
package mp_fifo_pkg;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // Length of the unbroken run of ones starting at bit 0.
  function automatic int unsigned leading_ones(input logic [31:0] v);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      run = run & v[i];
      if (run) n++;
    end
    return n;
  endfunction

  // n never exceeds depth, so a single conditional subtract is a full modulo.
  function automatic int unsigned wrap_add(input int unsigned ptr, input int unsigned n,
                                           input int unsigned depth);
    int unsigned s;
    s = ptr + n;
    return (s >= depth) ? (s - depth) : s;
  endfunction

endpackage

// File: rtl/mp_fifo_ptr_ctrl.sv
// Head/tail pointers, registered occupancy and almost-full flag for mp_fifo_compact.
module mp_fifo_ptr_ctrl
  import mp_fifo_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_THRESH = 4,
  localparam int unsigned PW          = ptr_w(DEPTH),
  localparam int unsigned CW          = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic [CW-1:0] enq_n_i,
  input  logic [CW-1:0] deq_n_i,
  output logic [PW-1:0] head_o,
  output logic [PW-1:0] tail_o,
  output logic [CW-1:0] count_o,
  output logic          almost_full_o
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          af_q, af_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      af_q    <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      af_q    <= af_d;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    af_d    = af_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      af_d    = 1'b0;
    end else begin
      head_d  = PW'(wrap_add(32'(head_q), 32'(deq_n_i), DEPTH));
      tail_d  = PW'(wrap_add(32'(tail_q), 32'(enq_n_i), DEPTH));
      count_d = count_q + enq_n_i - deq_n_i;
      af_d    = (DEPTH - 32'(count_d)) <= AFULL_THRESH;
    end
  end

  assign head_o        = head_q;
  assign tail_o        = tail_q;
  assign count_o       = count_q;
  assign almost_full_o = af_q;

endmodule

// File: rtl/mp_fifo_compact.sv
// Multi-lane enqueue/dequeue FIFO with sparse-lane compaction.
// Optional MP_FIFO_BYPASS_EN: zero-latency pass-through of fired lanes when empty.
module mp_fifo_compact
  import mp_fifo_pkg::*;
#(
  parameter int unsigned PAYLOAD_WIDTH = 32,
  parameter int unsigned ENQ_WIDTH     = 4,
  parameter int unsigned DEQ_WIDTH     = 4,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned AFULL_THRESH  = 4,
  localparam int unsigned CW           = cnt_w(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush_i,
  input  logic [ENQ_WIDTH-1:0]               enq_vld_i,
  input  logic [PAYLOAD_WIDTH*ENQ_WIDTH-1:0] enq_payload_i,
  output logic [ENQ_WIDTH-1:0]               enq_rdy_o,
  output logic [DEQ_WIDTH-1:0]               deq_vld_o,
  output logic [PAYLOAD_WIDTH*DEQ_WIDTH-1:0] deq_payload_o,
  input  logic [DEQ_WIDTH-1:0]               deq_rdy_i,
  output logic [CW-1:0]                      count_o,
  output logic                               almost_full_o
);

  localparam int unsigned PW = ptr_w(DEPTH);

  logic [PAYLOAD_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]            head, tail;
  logic [31:0]              free_slots;
  logic [ENQ_WIDTH-1:0]     enq_fire;
  int unsigned              enq_rank [ENQ_WIDTH];
  logic [CW-1:0]            enq_n, deq_n, byp_n, wr_n, rd_n;
  logic                     byp_act;

  // Acceptance looks only at the registered count, never at this cycle's dequeue.
  always_comb begin
    enq_rdy_o  = '0;
    free_slots = DEPTH - 32'(count_o);
    for (int unsigned i = 0; i < ENQ_WIDTH; i++) begin
      enq_rdy_o[i] = !flush_i &&
                     (free_slots > popcount(32'(enq_vld_i) & ((32'd1 << i) - 32'd1)));
    end
  end

  assign enq_fire = enq_vld_i & enq_rdy_o;
  assign enq_n    = CW'(popcount(32'(enq_fire)));

  always_comb begin
    for (int unsigned i = 0; i < ENQ_WIDTH; i++) begin
      enq_rank[i] = popcount(32'(enq_fire) & ((32'd1 << i) - 32'd1));
    end
  end

`ifdef MP_FIFO_BYPASS_EN
  logic [PAYLOAD_WIDTH-1:0] byp_data [DEQ_WIDTH];

  always_comb begin
    for (int unsigned j = 0; j < DEQ_WIDTH; j++) begin
      byp_data[j] = '0;
      for (int unsigned i = 0; i < ENQ_WIDTH; i++) begin
        if (enq_fire[i] && (enq_rank[i] == j)) begin
          byp_data[j] = enq_payload_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        end
      end
    end
  end

  assign byp_act = (count_o == '0) && !flush_i;
`else
  assign byp_act = 1'b0;
`endif

  always_comb begin
    deq_vld_o     = '0;
    deq_payload_o = '0;
    for (int unsigned j = 0; j < DEQ_WIDTH; j++) begin
      deq_vld_o[j] = !flush_i && (32'(count_o) > j);
      deq_payload_o[j*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] =
        mem[PW'(wrap_add(32'(head), j, DEPTH))];
`ifdef MP_FIFO_BYPASS_EN
      if (byp_act) begin
        deq_vld_o[j] = j < 32'(enq_n);
        deq_payload_o[j*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = byp_data[j];
      end
`endif
    end
  end

  // Only the unbroken run of ready lanes from lane 0 consumes.
  assign deq_n = CW'(leading_ones(32'(deq_vld_o & deq_rdy_i)));
  assign byp_n = byp_act ? deq_n : '0;
  assign wr_n  = enq_n - byp_n;
  assign rd_n  = byp_act ? '0 : deq_n;

  // Storage is deliberately not reset; pointers alone define contents.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ENQ_WIDTH; i++) begin
      if (enq_fire[i] && (enq_rank[i] >= 32'(byp_n))) begin
        mem[PW'(wrap_add(32'(tail), enq_rank[i] - 32'(byp_n), DEPTH))] <=
          enq_payload_i[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      end
    end
  end

  mp_fifo_ptr_ctrl #(
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL_THRESH)
  ) u_ptr_ctrl (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .enq_n_i       (wr_n),
    .deq_n_i       (rd_n),
    .head_o        (head),
    .tail_o        (tail),
    .count_o       (count_o),
    .almost_full_o (almost_full_o)
  );

endmodule

// File: tb/tb_mp_fifo_compact.sv
// Bench for mp_fifo_compact: DEPTH=16 and DEPTH=12 instances share stimulus and are
// checked every cycle against a list-based model, plus hand-computed literals.
module tb_mp_fifo_compact;

`ifdef MP_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   enq_vld, deq_rdy;
  logic [127:0] enq_pl;
  logic [3:0]   enq_rdy_w [2];
  logic [3:0]   deq_vld_w [2];
  logic [127:0] deq_pl_w  [2];
  logic         af_w      [2];
  logic [4:0]   cnt16;
  logic [3:0]   cnt12;

  int checks   = 0;
  int failures = 0;
  int unsigned seq = 1;

  // Model: per instance an ordered list of stored items, oldest at index 0.
  logic [31:0] items   [2][64];
  int unsigned n_items [2];
  bit          af_m    [2];
  logic [3:0]  exp_rdy;
  logic [31:0] fired   [4];
  int unsigned fired_n;
  logic [31:0] vis     [4];
  int unsigned vis_n;
  bit          byp_mode;
  logic [7:0]  sp      [6];

  always #5 clk = ~clk;

  mp_fifo_compact #(.DEPTH(16)) dut16 (
    .clk(clk), .rst(rst), .flush_i(flush), .enq_vld_i(enq_vld), .enq_payload_i(enq_pl),
    .enq_rdy_o(enq_rdy_w[0]), .deq_vld_o(deq_vld_w[0]), .deq_payload_o(deq_pl_w[0]),
    .deq_rdy_i(deq_rdy), .count_o(cnt16), .almost_full_o(af_w[0])
  );

  mp_fifo_compact #(.DEPTH(12)) dut12 (
    .clk(clk), .rst(rst), .flush_i(flush), .enq_vld_i(enq_vld), .enq_payload_i(enq_pl),
    .enq_rdy_o(enq_rdy_w[1]), .deq_vld_o(deq_vld_w[1]), .deq_payload_o(deq_pl_w[1]),
    .deq_rdy_i(deq_rdy), .count_o(cnt12), .almost_full_o(af_w[1])
  );

  function automatic int unsigned dep(input int m);
    return (m == 0) ? 16 : 12;
  endfunction

  function automatic logic [31:0] cnt_of(input int m);
    return (m == 0) ? 32'(cnt16) : 32'(cnt12);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic evaluate(input int m);
    int unsigned free_n, below;
    free_n  = dep(m) - n_items[m];
    below   = 0;
    fired_n = 0;
    for (int i = 0; i < 4; i++) begin
      exp_rdy[i] = !flush && (free_n > below);
      if (enq_vld[i]) below++;
      if (enq_vld[i] && exp_rdy[i]) begin
        fired[fired_n] = enq_pl[32*i +: 32];
        fired_n++;
      end
    end
    byp_mode = BYP && (n_items[m] == 0) && !flush;
    vis_n = 0;
    for (int j = 0; j < 4; j++) begin
      if (byp_mode) begin
        if (j < int'(fired_n)) begin vis[vis_n] = fired[j]; vis_n++; end
      end else if (!flush && (j < int'(n_items[m]))) begin
        vis[vis_n] = items[m][j];
        vis_n++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] ev;
    for (int m = 0; m < 2; m++) begin
      evaluate(m);
      ev = '0;
      for (int j = 0; j < 4; j++) ev[j] = (j < int'(vis_n));
      chk($sformatf("d%0d_enq_rdy", dep(m)), 32'(enq_rdy_w[m]), 32'(exp_rdy));
      chk($sformatf("d%0d_deq_vld", dep(m)), 32'(deq_vld_w[m]), 32'(ev));
      for (int j = 0; j < int'(vis_n); j++)
        chk($sformatf("d%0d_deq_lane%0d", dep(m), j), deq_pl_w[m][32*j +: 32], vis[j]);
      chk($sformatf("d%0d_count", dep(m)), cnt_of(m), n_items[m]);
      chk($sformatf("d%0d_afull", dep(m)), 32'(af_w[m]), 32'(af_m[m]));
    end
  endtask

  task automatic update_model();
    int unsigned dn;
    bit run;
    for (int m = 0; m < 2; m++) begin
      evaluate(m);
      if (flush) begin
        n_items[m] = 0;
        af_m[m]    = 1'b0;
      end else begin
        dn  = 0;
        run = 1'b1;
        for (int j = 0; j < 4; j++) begin
          if (run && (j < int'(vis_n)) && deq_rdy[j]) dn++;
          else run = 1'b0;
        end
        if (byp_mode) begin
          for (int unsigned k = dn; k < fired_n; k++) begin
            items[m][n_items[m]] = fired[k];
            n_items[m]++;
          end
        end else begin
          for (int unsigned k = 0; k + dn < n_items[m]; k++) items[m][k] = items[m][k+dn];
          n_items[m] = n_items[m] - dn;
          for (int unsigned k = 0; k < fired_n; k++) begin
            items[m][n_items[m]] = fired[k];
            n_items[m]++;
          end
        end
        af_m[m] = (dep(m) - n_items[m]) <= 4;
      end
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      n_items[m] = 0;
      af_m[m]    = 1'b0;
    end
  endtask

  task automatic drive_pl(input logic [3:0] ev, input logic [127:0] pl, input logic [3:0] dr,
                          input logic fl);
    enq_vld = ev;
    enq_pl  = pl;
    deq_rdy = dr;
    flush   = fl;
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic [3:0] ev, input logic [3:0] dr, input logic fl);
    logic [127:0] pl;
    for (int i = 0; i < 4; i++) begin
      pl[32*i +: 32] = 32'hC000_0000 + seq;
      seq++;
    end
    drive_pl(ev, pl, dr, fl);
  endtask

  task automatic tick();
    update_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] pl;
    rst = 1'b0; flush = 1'b0; enq_vld = '0; deq_rdy = '0; enq_pl = '0;
    model_reset();
    #12;
    chk("rst_count", 32'(cnt16), 32'd0);
    chk("rst_afull", 32'(af_w[0]), 32'd0);
    chk("rst_deq_vld", 32'(deq_vld_w[0]), 32'd0);
    chk("rst_enq_rdy", 32'(enq_rdy_w[0]), 32'hF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Sparse lanes 1 and 3 compact into the two oldest slots.
    pl = '0;
    pl[63:32]   = 32'h0000_00AA;
    pl[127:96]  = 32'h0000_00BB;
    drive_pl(4'b1010, pl, 4'b0000, 1'b0);
    tick();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("r032_count", 32'(cnt16), 32'd2);
    chk("r032_deq_vld", 32'(deq_vld_w[0]), 32'h3);
    chk("r032_lane0", deq_pl_w[0][31:0], 32'h0000_00AA);
    chk("r032_lane1", deq_pl_w[0][63:32], 32'h0000_00BB);
    tick();

    for (int c = 0; c < 3; c++) begin drive(4'b1111, 4'b0000, 1'b0); tick(); end
    drive(4'b1111, 4'b0000, 1'b0);
    chk("r033_rdy_at14", 32'(enq_rdy_w[0]), 32'h3);
    tick();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("r033_count16", 32'(cnt16), 32'd16);
    chk("r033_afull", 32'(af_w[0]), 32'd1);
    drive(4'b1111, 4'b1111, 1'b0);
    chk("r033_rdy_full", 32'(enq_rdy_w[0]), 32'h0);
    tick();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("r033_count12", 32'(cnt16), 32'd12);

    drive(4'b0000, 4'b1111, 1'b0); tick();
    drive(4'b0000, 4'b1111, 1'b0); tick();
    drive(4'b0000, 4'b0001, 1'b0); tick();
    drive(4'b0000, 4'b1101, 1'b0);
    chk("r034_deq_vld", 32'(deq_vld_w[0]), 32'h7);
    tick();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("r034_count", 32'(cnt16), 32'd2);
    tick();

    sp = '{8'b0101_0000, 8'b1001_0011, 8'b0110_0101, 8'b1000_1111, 8'b0011_0001,
           8'b1111_1011};
    for (int c = 0; c < 6; c++) begin drive(sp[c][7:4], sp[c][3:0], 1'b0); tick(); end

    drive(4'b0000, 4'b0000, 1'b1);
    tick();
    drive(4'b1111, 4'b0000, 1'b0); tick();
    drive(4'b1111, 4'b0000, 1'b0); tick();
    drive(4'b0001, 4'b0000, 1'b0); tick();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("r036_count9", 32'(cnt16), 32'd9);
    drive(4'b1111, 4'b0000, 1'b1);
    chk("r036_flush_rdy", 32'(enq_rdy_w[0]), 32'h0);
    chk("r036_flush_vld", 32'(deq_vld_w[0]), 32'h0);
    tick();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("r036_count0", 32'(cnt16), 32'd0);
    chk("r036_deq_vld0", 32'(deq_vld_w[0]), 32'h0);
    chk("r036_afull0", 32'(af_w[0]), 32'd0);

    pl = '0;
    pl[31:0]  = 32'h0000_0111;
    pl[63:32] = 32'h0000_0222;
    pl[95:64] = 32'h0000_0333;
    drive_pl(4'b0111, pl, 4'b0011, 1'b0);
`ifdef MP_FIFO_BYPASS_EN
    chk("r037_byp_vld", 32'(deq_vld_w[0]), 32'h7);
    chk("r037_byp_lane0", deq_pl_w[0][31:0], 32'h0000_0111);
    chk("r037_byp_lane1", deq_pl_w[0][63:32], 32'h0000_0222);
`else
    chk("r037_vld_empty", 32'(deq_vld_w[0]), 32'h0);
`endif
    tick();
    drive(4'b0000, 4'b0000, 1'b0);
`ifdef MP_FIFO_BYPASS_EN
    chk("r037_byp_count", 32'(cnt16), 32'd1);
    chk("r037_byp_left", deq_pl_w[0][31:0], 32'h0000_0333);
`else
    chk("r037_count", 32'(cnt16), 32'd3);
    chk("r037_head", deq_pl_w[0][31:0], 32'h0000_0111);
`endif
    tick();
    drive(4'b0000, 4'b1111, 1'b0); tick();

    // Streaming: 4 in, 3 out per cycle wraps both pointers on both depths.
    for (int c = 0; c < 20; c++) begin drive(4'b1111, 4'b0111, 1'b0); tick(); end

    rst = 1'b0;
    #1;
    chk("r036_rst_count16", 32'(cnt16), 32'd0);
    chk("r036_rst_count12", 32'(cnt12), 32'd0);
    chk("r036_rst_vld", 32'(deq_vld_w[0]), 32'h0);
    chk("r036_rst_rdy", 32'(enq_rdy_w[0]), 32'hF);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(4'b1111, 4'b0111, 1'b0); tick();
    for (int c = 0; c < 8; c++) begin drive(4'b0000, 4'b1111, 1'b0); tick(); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mp_fifo_compact.md
MP_FIFO_COMPACT -- requirements
Module: mp_fifo_compact

Interface
REQ-001 SHALL have parameter PAYLOAD_WIDTH, default 32, bits per entry.
REQ-002 SHALL have parameter ENQ_WIDTH, default 4, enqueue lanes.
REQ-003 SHALL have parameter DEQ_WIDTH, default 4, dequeue lanes.
REQ-004 SHALL have parameter DEPTH, default 16, entries; any value >= max(ENQ_WIDTH, DEQ_WIDTH), power of two not required.
REQ-005 SHALL have parameter AFULL_THRESH, default 4, free-entry level for almost_full_o.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port flush_i  input  1  synchronous discard of all contents.
REQ-009 SHALL have port enq_vld_i  input  ENQ_WIDTH  per-lane enqueue valid; sparse patterns allowed.
REQ-010 SHALL have port enq_payload_i  input  PAYLOAD_WIDTH*ENQ_WIDTH  lane i at [i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH].
REQ-011 SHALL have port enq_rdy_o  output  ENQ_WIDTH  per-lane accept.
REQ-012 SHALL have port deq_vld_o  output  DEQ_WIDTH  per-lane entry available.
REQ-013 SHALL have port deq_payload_o  output  PAYLOAD_WIDTH*DEQ_WIDTH  lane j = j-th oldest entry.
REQ-014 SHALL have port deq_rdy_i  input  DEQ_WIDTH  per-lane consumer ready.
REQ-015 SHALL have port count_o  output  $clog2(DEPTH+1)  registered occupancy.
REQ-016 SHALL have port almost_full_o  output  1  registered, high when DEPTH-count_o <= AFULL_THRESH.

Function
REQ-017 enq_rdy_o[i] SHALL equal (DEPTH-count_o) > popcount(enq_vld_i[i-1:0]) and !flush_i; free space from registered count only (no deq-to-enq comb path).
REQ-018 Enqueue fire = enq_vld_i & enq_rdy_o; k-th fired lane (ascending lane order) SHALL write slot (tail+k) mod DEPTH; gaps compacted, order preserved.
REQ-019 deq_vld_o[j] SHALL equal count_o > j and !flush_i; deq_payload_o lane j SHALL be mem[(head+j) mod DEPTH].
REQ-020 Dequeue count SHALL be the number of leading ones from lane 0 of deq_vld_o & deq_rdy_i; a ready lane above a gap SHALL NOT consume.
REQ-021 Next cycle: head += deq_n, tail += enq_n, both mod DEPTH with explicit wrap (non-power-of-two safe); count_o += enq_n - deq_n.
REQ-022 Simultaneous enqueue and dequeue at full/empty SHALL behave per REQ-017/019 (full: no enqueue even if dequeue fires; empty: no dequeue of same-cycle enqueue, unless REQ-028).
REQ-023 Minimum enqueue-to-dequeue latency SHALL be 1 cycle.
REQ-024 flush_i high: all fires suppressed, next cycle head=tail=count_o=0, almost_full_o=0.
REQ-025 Payload storage SHALL not be reset or cleared by flush.

Reset
REQ-026 rst low SHALL asynchronously set head=0, tail=0, count_o=0, almost_full_o=0; consequently deq_vld_o=0 and enq_rdy_o=all ones (flush_i low).
REQ-027 Reset asserted mid-operation SHALL drop all contents; first cycle after release behaves as empty FIFO.

Configuration
REQ-028 Macro MP_FIFO_BYPASS_EN defined: when count_o==0 and !flush_i, deq_vld_o/deq_payload_o lane j SHALL present the j-th compacted fired enqueue lane combinationally; bypassed fires consume without write, remaining fired lanes written from tail; latency 0.
REQ-029 Macro undefined: no enqueue-to-dequeue comb path; REQ-023 holds.

Structure
REQ-030 Package mp_fifo_pkg SHALL hold ptr/cnt width functions, popcount and leading-ones functions, and a wrap-add function (ptr+n mod DEPTH).
REQ-031 Pointer/count/almost-full state SHALL live in sub-module mp_fifo_ptr_ctrl; storage and lane compaction in top.

Verification (DEPTH=16, ENQ_WIDTH=DEQ_WIDTH=4, AFULL_THRESH=4)
REQ-032 Reset, enq_vld_i=4'b1010 payloads A(lane1),B(lane3) -> next cycle count_o=2, deq lane0=A, lane1=B, deq_vld_o=4'b0011.
REQ-033 count_o=14, enq_vld_i=4'b1111 -> enq_rdy_o=4'b0011, count_o=16, almost_full_o=1; deq_rdy_i=4'b1111 same cycle at 16 -> enq_rdy_o=0, count_o=12.
REQ-034 count_o=3, deq_rdy_i=4'b1101 -> only lane0 consumed, count_o=2, head+1.
REQ-035 Enqueue 4/cycle, dequeue 3/cycle for 20 cycles -> head/tail wrap repeatedly, dequeued stream equals enqueued order; repeat with DEPTH=12.
REQ-036 count_o=9, flush_i=1 with enq_vld_i=4'b1111 -> enq_rdy_o=0, next cycle count_o=0, deq_vld_o=0; rst pulse low mid-stream -> count_o=0 immediately.
REQ-037 MP_FIFO_BYPASS_EN, empty, enq_vld_i=4'b0111, deq_rdy_i=4'b0011 -> two items dequeued same cycle, next cycle count_o=1 holding third item; macro undefined -> deq_vld_o=0 same cycle, count_o=3.
